// File: rtl/rising_edge_generator.sv
// Purpose: turns each one-cycle request into one clean low-then-high waveform on o_x.
// Latency: o_x is low for LOW_CYCLES cycles starting the cycle after a launch, then high for HIGH_CYCLES.
// Backpressure: requests queue in a saturating counter; at capacity a request is dropped and o_overflow sticks.
module rising_edge_generator #(
    parameter int LOW_CYCLES  = 1,
    parameter int HIGH_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    output logic             o_x,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_pending,
    output logic             o_overflow
);

    // Phase counter only has to reach the longer of the two phases.
    localparam int PH_MAX = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  LOW_LAST  = PH_W'(LOW_CYCLES - 1);
    localparam logic [PH_W-1:0]  HIGH_LAST = PH_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_nxt;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pending_nxt;
    logic             r_x;
    logic             r_overflow;
    logic             w_avail;
    logic             w_launch;
    logic             w_drop;

    // Next-state and launch decision: a launch is allowed in any idle cycle or in the
    // final high cycle, so queued waveforms follow each other with no idle gap.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_avail     = i_req | (r_pending != '0);
        case (r_state)
            S_IDLE: begin
                if (w_avail) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (r_phase == LOW_LAST) begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (r_phase == HIGH_LAST) begin
                    if (w_avail) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_LOW;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase restarts on every state change and stays parked at zero while idle.
    always_comb begin
        w_phase_nxt = r_phase + PH_W'(1);
        if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            w_phase_nxt = '0;
        end
    end

    // Pending-queue update: a request arriving in a launch cycle is consumed directly,
    // so only unmatched requests or launches move the count; it never wraps.
    always_comb begin
        w_pending_nxt = r_pending;
        w_drop        = 1'b0;
        case ({i_req, w_launch})
            2'b10: begin
                if (r_pending == CNT_MAX) begin
                    w_drop = 1'b1;
                end else begin
                    w_pending_nxt = r_pending + CNT_W'(1);
                end
            end
            2'b01: begin
                if (r_pending != '0) begin
                    w_pending_nxt = r_pending - CNT_W'(1);
                end
            end
            default: w_pending_nxt = r_pending;
        endcase
    end

    // State, phase, queue and registered outputs; reset aborts any waveform in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_pending  <= '0;
            r_x        <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_pending <= w_pending_nxt;
            r_x       <= (w_state_nxt == S_HIGH);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_x        = r_x;
    assign o_busy     = (r_state != S_IDLE);
    assign o_pending  = r_pending;
    assign o_overflow = r_overflow;

endmodule

// File: doc/rising_edge_generator.md
# rising_edge_generator

Transmit-side counterpart to the team's rising-edge detectors. Each one-cycle request pulse on `req` produces one clean low-then-high waveform on `x`. Back-to-back requests are queued in a saturating counter so that none is lost below capacity. Every waveform gives a downstream detector at least one low cycle followed by at least two high cycles, so each waveform yields exactly one detection.

## Interface
- `LOW_CYCLES`, default 1: cycles `x` is held low per waveform; must be ≥1.
- `HIGH_CYCLES`, default 2: cycles `x` is held high per waveform; must be ≥2.
- `CNT_W`, default 4: width of the pending-request counter. Capacity is MAX = 2^CNT_W − 1.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, synchronous and active-high. It dominates all other inputs.
- `req` in 1: request. Each high cycle is one request.
- `x` out 1: generated waveform, driven directly from a flop.
- `busy` out 1: high while a waveform is in progress (state ≠ IDLE).
- `pending` out CNT_W: number of queued requests not yet launched.
- `overflow` out 1: sticky flag, set when a request is dropped. Cleared only by `rst`.

## Operation
- **States:**
  - IDLE: `x`=0.
  - LOW: `x`=0, runs for LOW_CYCLES cycles.
  - HIGH: `x`=1, runs for HIGH_CYCLES cycles.
- **Phase counter:** counts cycles within LOW and HIGH. It is cleared on every state change.
- **Work available:** `avail` = `req` | (`pending` ≠ 0).
- **Launch:** a launch occurs in either of these cycles when `avail`=1:
  - any IDLE cycle;
  - the final HIGH cycle.
- **Transitions:**
  - A launch moves the FSM to LOW at the next edge.
  - Final cycle of LOW → HIGH.
  - Final cycle of HIGH without a launch → IDLE.
  - IDLE without `avail` → stays in IDLE.
- **Pending counter**, per cycle with `r`=`req` and `l`=launch:
  - `r`=1, `l`=0, `pending` < MAX: `pending`+1.
  - `r`=1, `l`=0, `pending` = MAX: request dropped, `overflow`←1, `pending` unchanged.
  - `r`=0, `l`=1: `pending`−1. A launch with `req`=0 implies `pending` ≥ 1.
  - `r`=1, `l`=1: `pending` unchanged. The request is consumed directly, or replaces the dequeued one.
  - `r`=0, `l`=0: unchanged.
- **Width rules:** `pending` never wraps in either direction. The phase counter is sized for max(LOW_CYCLES, HIGH_CYCLES).
- **Outputs:** `busy` is combinational from state. `x` and `pending` are registered.

## Timing
- **Reset values:** state=IDLE, `x`=0, `busy`=0, `pending`=0, `overflow`=0, phase=0.
- **Reset mid-waveform:** the waveform is aborted. `x`=0 from the cycle after `rst` is sampled. The queue is discarded and `overflow` is cleared.
- **Single-request latency:** with `req` sampled in IDLE at cycle k:
  - `x`=0 in cycles k+1 … k+LOW_CYCLES;
  - `x`=1 in cycles k+LOW_CYCLES+1 … k+LOW_CYCLES+HIGH_CYCLES;
  - `busy`=1 over the same span.
- **Throughput:** one waveform per LOW_CYCLES+HIGH_CYCLES cycles. There is no IDLE gap between queued waveforms: the last HIGH cycle is followed directly by LOW.
- **Edge count:** exactly one rising edge of `x` per accepted request. `x` never rises twice within one waveform.

## Test plan
1. **Single request, defaults:** after reset, `req`=1 in cycle 0 only.
   - `x`=0 in cycle 1; `x`=1 in cycles 2–3; `busy`=1 in cycles 1–3.
   - IDLE with `x`=0, `busy`=0 in cycle 4; `pending`=0 throughout.
2. **Back-to-back requests, defaults:** `req`=1 in cycles 0, 1, 2.
   - `pending` reads 1 then 2 (after the edges ending cycles 1 and 2).
   - `x` = 0,1,1 repeated three times over cycles 1–9.
   - `busy` falls in cycle 10; `overflow`=0.
3. **Overflow:** `CNT_W`=2, `req` held high in cycles 0–7.
   - Requests in cycles 5 and 7 are dropped; `overflow`=1 from cycle 6 and stays high.
   - Exactly 6 waveforms are produced, launched at cycles 0, 3, 6, 9, 12, 15.
   - `pending` peaks at 3 and ends at 0.
4. **Reset mid-HIGH:** `req` in cycle 0, `rst`=1 in cycle 2.
   - From cycle 3: `x`=0, `busy`=0, `pending`=0.
   - A new `req` in cycle 5 yields a normal waveform: `x` high in cycles 7–8.
5. **Parameter sweep:** `LOW_CYCLES`=3, `HIGH_CYCLES`=4, single `req` in cycle 0.
   - `x`=0 in cycles 1–3, `x`=1 in cycles 4–7, IDLE in cycle 8.
6. **Loopback:** `x` feeds a rising-edge detector; 20 random `req` pulses with no overflow.
   - The detector emits exactly 20 one-cycle pulses.
   - Each pulse occurs in the second high cycle of its waveform.
